// File: rtl/ex_mem_branch_stage.sv
// ex_mem_branch_stage: EX->MEM register with branch resolve,
// 2-entry skid buffer and branch performance counters.
module ex_mem_branch_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic [2:0]        BranchTypeE,
  input  logic [REG_AW-1:0] RdE,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic              ZeroE,
  input  logic              NegativeE,
  input  logic              OverFlowE,
  input  logic              CarryE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [DATA_W-1:0] PCTargetE,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetOut,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_AW-1:0] RdM,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M,
  output logic [CNT_W-1:0]  BranchCount,
  output logic [CNT_W-1:0]  TakenCount
);

  typedef struct packed {
    logic              rw;
    logic              mw;
    logic [1:0]        rs;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc4;
  } pkt_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t           r_state;
  state_t           w_next;
  pkt_t             r_head;
  pkt_t             r_tail;
  pkt_t             w_in;
  logic [CNT_W-1:0] r_bcnt;
  logic [CNT_W-1:0] r_tcnt;
  logic             w_accept;
  logic             w_pop;
  logic             w_cond;
  logic             w_taken;
  logic             w_ld_head;
  logic             w_ld_tail;
  logic             w_promote;
  logic             w_valid;

  assign w_in = '{
    rw:  RegWriteE,
    mw:  MemWriteE,
    rs:  ResultSrcE,
    rd:  RdE,
    alu: ALUResultE,
    wd:  WriteDataE,
    pc4: PCPlus4E
  };

  assign w_valid  = (r_state != S_EMPTY);
  assign InReady  = rst & (r_state != S_FULL);
  assign w_accept = InValid & InReady;
  assign w_pop    = w_valid & OutReady;

  // Branch condition from the SUB-mode ALU flags.
  always_comb begin
    w_cond = 1'b0;
    case (BranchTypeE)
      3'b000:  w_cond = ZeroE;
      3'b001:  w_cond = ~ZeroE;
      3'b100:  w_cond = NegativeE ^ OverFlowE;
      3'b101:  w_cond = ~(NegativeE ^ OverFlowE);
      3'b110:  w_cond = CarryE;
      3'b111:  w_cond = ~CarryE;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken     = JumpE | (BranchE & w_cond);
  assign PCSrcE      = w_accept & w_taken;
  assign PCTargetOut = PCTargetE;

  // Skid buffer next-state and entry load controls.
  always_comb begin
    w_next    = r_state;
    w_ld_head = 1'b0;
    w_ld_tail = 1'b0;
    w_promote = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_next    = S_ONE;
          w_ld_head = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_pop) begin
          w_ld_head = 1'b1;
        end else if (w_pop) begin
          w_next = S_EMPTY;
        end else if (w_accept) begin
          w_next    = S_FULL;
          w_ld_tail = 1'b1;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_next    = S_ONE;
          w_promote = 1'b1;
        end
      end
      default: w_next = S_EMPTY;
    endcase
  end

  // Skid buffer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_EMPTY;
    else      r_state <= w_next;
  end

  // Head holds the oldest packet; tail only used when full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_ld_head)      r_head <= w_in;
      else if (w_promote) r_head <= r_tail;
      if (w_ld_tail)      r_tail <= w_in;
    end
  end

  // Branch performance counters, free-running wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcnt <= '0;
      r_tcnt <= '0;
    end else begin
      if (w_accept && BranchE) r_bcnt <= r_bcnt + CNT_W'(1);
      if (w_accept && w_taken) r_tcnt <= r_tcnt + CNT_W'(1);
    end
  end

  assign OutValid    = w_valid;
  assign RegWriteM   = r_head.rw & w_valid;
  assign MemWriteM   = r_head.mw & w_valid;
  assign ResultSrcM  = r_head.rs;
  assign RdM         = r_head.rd;
  assign ALUResultM  = r_head.alu;
  assign WriteDataM  = r_head.wd;
  assign PCPlus4M    = r_head.pc4;
  assign BranchCount = r_bcnt;
  assign TakenCount  = r_tcnt;

endmodule
